// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
//   Accepts a WIDTH-bit operand pair over a valid/ready handshake. Feeds the pair
//   LSB-first through a single full adder, one bit per clock, and returns the
//   WIDTH-bit sum and carry-out over a valid/ready result port.
//   Optional macro SERIAL_ADD_OVF_EN adds the ovf_o port (two's-complement overflow).
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-high
//   in_valid_i   operand set valid
//   in_ready_o   block can accept operands (IDLE)
//   op_a_i       addend A
//   op_b_i       addend B
//   op_cin_i     carry-in to bit 0
//   out_valid_o  result valid (DONE)
//   out_ready_i  consumer accepts result
//   sum_o        registered sum
//   cout_o       registered carry-out of the MSB
//   busy_o       high in RUN or DONE
//   ovf_o        signed overflow (SERIAL_ADD_OVF_EN only)

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ cin_i;
   assign co_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             op_cin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             busy_o
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   // One extra bit so the counter can reach WIDTH without wrapping.
   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  sh_a_q, sh_a_d;
   logic [WIDTH-1:0]  sh_b_q, sh_b_d;
   logic              carry_q, carry_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
   logic              ovf_q, ovf_d;
`endif

   logic              fa_s, fa_co;
   logic [WIDTH-1:0]  sum_shift;

   full_adder u_fa (
      .a_i  (sh_a_q[0]),
      .b_i  (sh_b_q[0]),
      .cin_i(carry_q),
      .s_o  (fa_s),
      .co_o (fa_co)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at sum[0].
   if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_s;
   end else begin : g_sum_wn
      assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      sh_a_d  = sh_a_q;
      sh_b_d  = sh_b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               sh_a_d  = op_a_i;
               sh_b_d  = op_b_i;
               carry_d = op_cin_i;
               cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d   = sum_shift;
            sh_a_d  = sh_a_q >> 1;
            sh_b_d  = sh_b_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
               // carry_q is the carry into the MSB on the last bit.
               ovf_d   = carry_q ^ fa_co;
`endif
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StDone);
   assign busy_o      = (state_q == StRun) || (state_q == StDone);
   assign sum_o       = sum_q;
   assign cout_o      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed table-driven bench for serial_add_ctrl.
//   Drives a WIDTH=8 instance and a WIDTH=1 instance; sel chooses which one the
//   shared stimulus tasks talk to.

module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sel = 1'b0;  // 0: WIDTH=8 instance, 1: WIDTH=1 instance
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] op_a = '0;
   logic [7:0] op_b = '0;
   logic       op_cin = 1'b0;

   logic       in_ready8, out_valid8, cout8, busy8, ovf8;
   logic [7:0] sum8;
   logic       in_ready1, out_valid1, cout1, busy1, ovf1;
   logic [0:0] sum1;

   logic       in_ready, out_valid, cout, busy, ovf;
   logic [7:0] sum;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_valid_i (in_valid & ~sel),
      .in_ready_o (in_ready8),
      .op_a_i     (op_a),
      .op_b_i     (op_b),
      .op_cin_i   (op_cin),
      .out_valid_o(out_valid8),
      .out_ready_i(out_ready & ~sel),
      .sum_o      (sum8),
      .cout_o     (cout8),
      .busy_o     (busy8)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf_o      (ovf8)
`endif
   );

   serial_add_ctrl #(.WIDTH(1)) u_dut1 (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_valid_i (in_valid & sel),
      .in_ready_o (in_ready1),
      .op_a_i     (op_a[0:0]),
      .op_b_i     (op_b[0:0]),
      .op_cin_i   (op_cin),
      .out_valid_o(out_valid1),
      .out_ready_i(out_ready & sel),
      .sum_o      (sum1),
      .cout_o     (cout1),
      .busy_o     (busy1)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf_o      (ovf1)
`endif
   );

`ifndef SERIAL_ADD_OVF_EN
   assign ovf8 = 1'b0;
   assign ovf1 = 1'b0;
`endif

   assign in_ready  = sel ? in_ready1  : in_ready8;
   assign out_valid = sel ? out_valid1 : out_valid8;
   assign cout      = sel ? cout1      : cout8;
   assign busy      = sel ? busy1      : busy8;
   assign ovf       = sel ? ovf1       : ovf8;
   assign sum       = sel ? {7'b0, sum1} : sum8;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_sum;
      logic       exp_cout;
      logic       exp_ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and wait (bounded) for out_valid. cycles counts edges
   // after the handshake edge until out_valid is seen.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input bit release_res, output logic [7:0] r_sum,
                         output logic r_cout, output logic r_ovf, output int cycles);
      op_a = a;
      op_b = b;
      op_cin = cin;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < 100) begin
         step();
         cycles++;
      end
      r_sum  = sum;
      r_cout = cout;
      r_ovf  = ovf;
      if (release_res) begin
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask

   initial begin
      vec_t       vecs[7];
      logic [7:0] r_sum;
      logic       r_cout, r_ovf;
      int         cyc;
      logic [7:0] held_sum;
      logic       held_cout;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

      // Reset state, sampled while rst is still high.
      step();
      step();
      check("rst in_ready", in_ready, 1);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst sum", sum, 0);
      check("rst cout", cout, 0);
      rst = 1'b0;
      step();

      // Directed vectors on WIDTH=8.
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, r_sum, r_cout, r_ovf, cyc);
         check($sformatf("vec%0d latency", i), cyc, 8);
         check($sformatf("vec%0d sum", i), r_sum, vecs[i].exp_sum);
         check($sformatf("vec%0d cout", i), r_cout, vecs[i].exp_cout);
`ifdef SERIAL_ADD_OVF_EN
         check($sformatf("vec%0d ovf", i), r_ovf, vecs[i].exp_ovf);
`endif
         check($sformatf("vec%0d in_ready after accept", i), in_ready, 1);
         check($sformatf("vec%0d out_valid pulse", i), out_valid, 0);
      end

      // Backpressure: hold result in DONE, offer ignored operands.
      run_op(8'h20, 8'h03, 1'b0, 1'b0, r_sum, r_cout, r_ovf, cyc);
      check("bp sum", r_sum, 8'h23);
      held_sum  = r_sum;
      held_cout = r_cout;
      op_a = 8'h55;
      op_b = 8'h01;
      op_cin = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("bp out_valid c%0d", k), out_valid, 1);
         check($sformatf("bp sum c%0d", k), sum, held_sum);
         check($sformatf("bp cout c%0d", k), cout, held_cout);
         check($sformatf("bp in_ready c%0d", k), in_ready, 0);
         check($sformatf("bp busy c%0d", k), busy, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp idle out_valid", out_valid, 0);
      check("bp idle in_ready", in_ready, 1);
      check("bp idle busy", busy, 0);
      run_op(8'h55, 8'h01, 1'b0, 1'b1, r_sum, r_cout, r_ovf, cyc);
      check("bp next sum", r_sum, 8'h56);
      check("bp next latency", cyc, 8);

      // Reset mid-RUN at cnt=3.
      op_a = 8'hAA;
      op_b = 8'h55;
      op_cin = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      check("abort busy before rst", busy, 1);
      rst = 1'b1;
      #2;
      check("abort out_valid", out_valid, 0);
      check("abort sum", sum, 0);
      check("abort cout", cout, 0);
      check("abort in_ready", in_ready, 1);
      check("abort busy", busy, 0);
      step();
      rst = 1'b0;
      begin
         int seen = 0;
         for (int k = 0; k < 12; k++) begin
            step();
            if (out_valid) seen++;
         end
         check("abort no out_valid", seen, 0);
      end
      run_op(8'h03, 8'h04, 1'b0, 1'b1, r_sum, r_cout, r_ovf, cyc);
      check("abort next sum", r_sum, 8'h07);
      check("abort next cout", r_cout, 0);

      // WIDTH=1 instance: all eight input combinations.
      sel = 1'b1;
      step();
      for (int v = 7; v >= 0; v--) begin
         logic       a1, b1, c1;
         logic [1:0] e;
         a1 = v[2];
         b1 = v[1];
         c1 = v[0];
         e  = 2'(a1) + 2'(b1) + 2'(c1);
         run_op({7'b0, a1}, {7'b0, b1}, c1, 1'b1, r_sum, r_cout, r_ovf, cyc);
         check($sformatf("w1 %0d%0d%0d latency", a1, b1, c1), cyc, 1);
         check($sformatf("w1 %0d%0d%0d sum", a1, b1, c1), r_sum, {7'b0, e[0]});
         check($sformatf("w1 %0d%0d%0d cout", a1, b1, c1), r_cout, e[1]);
`ifdef SERIAL_ADD_OVF_EN
         // Only bit is the MSB, so its carry-in is cin.
         check($sformatf("w1 %0d%0d%0d ovf", a1, b1, c1), r_ovf, c1 ^ e[1]);
`endif
      end
      sel = 1'b0;
      step();

      // Random sweep on WIDTH=8 against an arithmetic model.
      for (int n = 0; n < 1000; n++) begin
         logic [7:0] a, b;
         logic       c;
         logic [8:0] e;
         logic       e_ovf;
         a = 8'($urandom);
         b = 8'($urandom);
         c = 1'($urandom);
         e = 9'(a) + 9'(b) + 9'(c);
         e_ovf = (a[7] == b[7]) && (e[7] != a[7]);
         run_op(a, b, c, 1'b1, r_sum, r_cout, r_ovf, cyc);
         check($sformatf("rand%0d %02h+%02h+%0d", n, a, b, c),
               {r_cout, r_sum, 8'(cyc)}, {e, 8'd8});
`ifdef SERIAL_ADD_OVF_EN
         check($sformatf("rand%0d ovf", n), r_ovf, e_ovf);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
